// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: control-bundle bit layout and shared constants for the 5-stage MIPS pipeline.
package mips_pipe_pkg;
    localparam int CTRL_W        = 10;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_HI = 9;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds a source of the instruction in ID.
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic       valid_idex,
    input  logic       memread_idex,
    input  logic [4:0] rt_idex,
    input  logic       valid_id,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       uses_rt_id,
    output logic       hazard
);
    // A load targeting $zero never produces a value worth waiting for.
    assign hazard = valid_idex & memread_idex & valid_id & (rt_idex != REG_ZERO) &
                    ((rt_idex == rs_id) | (uses_rt_id & (rt_idex == rt_id)));
endmodule

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional bubbleCount port/counter enabled by defining MIPS_IDEX_BUBBLE_CNT_EN.
module idex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_ID,
    input  logic [4:0]        regRs_ID,
    input  logic [4:0]        regRt_ID,
    input  logic [4:0]        regRd_ID,
    input  logic              usesRt_ID,
    input  logic [DATA_W-1:0] readData1_ID,
    input  logic [DATA_W-1:0] readData2_ID,
    input  logic [DATA_W-1:0] signExt_ID,
    input  logic [DATA_W-1:0] pc4_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic              flush_EX,
    input  logic              hold_MEM,
    output logic [4:0]        regRs_IDEX,
    output logic [4:0]        regRt_IDEX,
    output logic [4:0]        regRd_IDEX,
    output logic [DATA_W-1:0] readData1_IDEX,
    output logic [DATA_W-1:0] readData2_IDEX,
    output logic [DATA_W-1:0] signExt_IDEX,
    output logic [DATA_W-1:0] pc4_IDEX,
    output logic [CTRL_W-1:0] ctrl_IDEX,
    output logic              valid_IDEX,
`ifdef MIPS_IDEX_BUBBLE_CNT_EN
    output logic [31:0]       bubbleCount,
`endif
    output logic              stall_ID
);
    logic              valid_q, valid_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, sext_q, sext_d, pc4_q, pc4_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              hazard, load_bubble, load_id, hz_bubble;

    load_use_detect u_detect (
        .valid_idex   (valid_q),
        .memread_idex (ctrl_q[mips_pipe_pkg::CTRL_MEMREAD]),
        .rt_idex      (rt_q),
        .valid_id     (valid_ID),
        .rs_id        (regRs_ID),
        .rt_id        (regRt_ID),
        .uses_rt_id   (usesRt_ID),
        .hazard       (hazard)
    );

    // Flush outranks hold, which outranks the load-use bubble.
    always_comb begin
        load_bubble = flush_EX | (~hold_MEM & hazard);
        load_id     = ~flush_EX & ~hold_MEM & ~hazard;
        hz_bubble   = ~flush_EX & ~hold_MEM & hazard;
        valid_d     = load_bubble ? 1'b0 : load_id ? valid_ID : valid_q;
        rs_d        = load_bubble ? '0 : load_id ? regRs_ID : rs_q;
        rt_d        = load_bubble ? '0 : load_id ? regRt_ID : rt_q;
        rd_d        = load_bubble ? '0 : load_id ? regRd_ID : rd_q;
        rd1_d       = load_bubble ? '0 : load_id ? readData1_ID : rd1_q;
        rd2_d       = load_bubble ? '0 : load_id ? readData2_ID : rd2_q;
        sext_d      = load_bubble ? '0 : load_id ? signExt_ID : sext_q;
        pc4_d       = load_bubble ? '0 : load_id ? pc4_ID : pc4_q;
        ctrl_d      = load_bubble ? '0 : load_id ? (valid_ID ? ctrl_ID : '0) : ctrl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            sext_q  <= '0;
            pc4_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            sext_q  <= sext_d;
            pc4_q   <= pc4_d;
            ctrl_q  <= ctrl_d;
        end
    end

`ifdef MIPS_IDEX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q + 32'(hz_bubble);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bubble_cnt_q <= '0;
        else        bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubbleCount = bubble_cnt_q;
`endif

    assign stall_ID       = (hazard | hold_MEM) & ~flush_EX;
    assign valid_IDEX     = valid_q;
    assign regRs_IDEX     = rs_q;
    assign regRt_IDEX     = rt_q;
    assign regRd_IDEX     = rd_q;
    assign readData1_IDEX = rd1_q;
    assign readData2_IDEX = rd2_q;
    assign signExt_IDEX   = sext_q;
    assign pc4_IDEX       = pc4_q;
    assign ctrl_IDEX      = ctrl_q;
endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: table-driven hazard scenarios, hand-written hold/reset sequences and a
// randomized run, all checked against a behavioural model of the ID/EX register.
module tb_idex_stage;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 10;
    localparam logic [9:0] C_LW   = 10'h02B;
    localparam logic [9:0] C_ADD  = 10'h091;
    localparam logic [9:0] C_ADDI = 10'h021;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              valid_ID, usesRt_ID, flush_EX, hold_MEM;
    logic [4:0]        regRs_ID, regRt_ID, regRd_ID;
    logic [DATA_W-1:0] readData1_ID, readData2_ID, signExt_ID, pc4_ID;
    logic [CTRL_W-1:0] ctrl_ID;
    logic [4:0]        regRs_IDEX, regRt_IDEX, regRd_IDEX;
    logic [DATA_W-1:0] readData1_IDEX, readData2_IDEX, signExt_IDEX, pc4_IDEX;
    logic [CTRL_W-1:0] ctrl_IDEX;
    logic              valid_IDEX, stall_ID;
    logic [31:0]       bubbleCount;

    idex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID),
        .regRs_ID(regRs_ID), .regRt_ID(regRt_ID), .regRd_ID(regRd_ID), .usesRt_ID(usesRt_ID),
        .readData1_ID(readData1_ID), .readData2_ID(readData2_ID), .signExt_ID(signExt_ID),
        .pc4_ID(pc4_ID), .ctrl_ID(ctrl_ID), .flush_EX(flush_EX), .hold_MEM(hold_MEM),
        .regRs_IDEX(regRs_IDEX), .regRt_IDEX(regRt_IDEX), .regRd_IDEX(regRd_IDEX),
        .readData1_IDEX(readData1_IDEX), .readData2_IDEX(readData2_IDEX),
        .signExt_IDEX(signExt_IDEX), .pc4_IDEX(pc4_IDEX), .ctrl_IDEX(ctrl_IDEX),
        .valid_IDEX(valid_IDEX),
`ifdef MIPS_IDEX_BUBBLE_CNT_EN
        .bubbleCount(bubbleCount),
`endif
        .stall_ID(stall_ID)
    );
`ifndef MIPS_IDEX_BUBBLE_CNT_EN
    assign bubbleCount = '0;
`endif

    // Contents of the EX slot as the bench believes it to be.
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, se, pc4;
        logic [9:0]  ctrl;
    } ex_t;
    ex_t m;
    logic [31:0] m_cnt;
    int vectors = 0, miscompares = 0;

    typedef struct {
        logic v; logic [4:0] rs, rt, rd; logic u; logic [9:0] ctrl; logic fl, ho;
        logic e_stall, e_valid; logic [4:0] e_rs; logic [9:0] e_ctrl;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_h();
        return m.valid && m.ctrl[1] && valid_ID && m.rt != 5'd0 &&
               (m.rt == regRs_ID || (usesRt_ID && m.rt == regRt_ID));
    endfunction

    task automatic check_state();
        chk("stall_ID", stall_ID, (model_h() || hold_MEM) && !flush_EX);
        chk("valid_IDEX", valid_IDEX, m.valid);
        chk("regRs_IDEX", regRs_IDEX, m.rs);
        chk("regRt_IDEX", regRt_IDEX, m.rt);
        chk("regRd_IDEX", regRd_IDEX, m.rd);
        chk("readData1_IDEX", readData1_IDEX, m.d1);
        chk("readData2_IDEX", readData2_IDEX, m.d2);
        chk("signExt_IDEX", signExt_IDEX, m.se);
        chk("pc4_IDEX", pc4_IDEX, m.pc4);
        chk("ctrl_IDEX", ctrl_IDEX, m.ctrl);
`ifdef MIPS_IDEX_BUBBLE_CNT_EN
        chk("bubbleCount", bubbleCount, m_cnt);
`endif
    endtask

    task automatic check_zero();
        chk("rst.stall_ID", stall_ID, 0);
        chk("rst.valid_IDEX", valid_IDEX, 0);
        chk("rst.specifiers", {regRs_IDEX, regRt_IDEX, regRd_IDEX}, 0);
        chk("rst.data", readData1_IDEX | readData2_IDEX | signExt_IDEX | pc4_IDEX, 0);
        chk("rst.ctrl_IDEX", ctrl_IDEX, 0);
        chk("rst.bubbleCount", bubbleCount, 0);
    endtask

    task automatic cycle();
        logic h;
        #1;
        check_state();
        h = model_h();
        @(posedge clk);
        if (flush_EX) m = '{default: '0};
        else if (hold_MEM) m = m;
        else if (h) begin
            m = '{default: '0};
            m_cnt++;
        end else m = '{valid_ID, regRs_ID, regRt_ID, regRd_ID, readData1_ID, readData2_ID,
                       signExt_ID, pc4_ID, valid_ID ? ctrl_ID : 10'd0};
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, rt, rd, input logic u,
                         input logic [9:0] c, input logic fl, ho);
        valid_ID = v; regRs_ID = rs; regRt_ID = rt; regRd_ID = rd; usesRt_ID = u;
        ctrl_ID = c; flush_EX = fl; hold_MEM = ho;
        readData1_ID = $urandom; readData2_ID = $urandom;
        signExt_ID = $urandom; pc4_ID = $urandom;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd2, 5'd8, 5'd0, 1'b0, C_LW,   1'b0, 1'b0, 1'b0, 1'b1, 5'd2, C_LW};
        tbl[1]  = '{1'b1, 5'd8, 5'd3, 5'd9, 1'b1, C_ADD,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 10'd0};
        tbl[2]  = '{1'b1, 5'd8, 5'd3, 5'd9, 1'b1, C_ADD,  1'b0, 1'b0, 1'b0, 1'b1, 5'd8, C_ADD};
        tbl[3]  = '{1'b1, 5'd2, 5'd0, 5'd0, 1'b0, C_LW,   1'b0, 1'b0, 1'b0, 1'b1, 5'd2, C_LW};
        tbl[4]  = '{1'b1, 5'd0, 5'd0, 5'd9, 1'b1, C_ADD,  1'b0, 1'b0, 1'b0, 1'b1, 5'd0, C_ADD};
        tbl[5]  = '{1'b1, 5'd2, 5'd8, 5'd0, 1'b0, C_LW,   1'b0, 1'b0, 1'b0, 1'b1, 5'd2, C_LW};
        tbl[6]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, C_ADDI, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 10'd0};
        tbl[7]  = '{1'b1, 5'd2, 5'd8, 5'd0, 1'b0, C_LW,   1'b0, 1'b0, 1'b0, 1'b1, 5'd2, C_LW};
        tbl[8]  = '{1'b1, 5'd4, 5'd8, 5'd0, 1'b0, C_ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, C_ADDI};
        tbl[9]  = '{1'b0, 5'd5, 5'd6, 5'd7, 1'b1, C_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 10'd0};
        tbl[10] = '{1'b1, 5'd2, 5'd8, 5'd0, 1'b0, C_LW,   1'b0, 1'b0, 1'b0, 1'b1, 5'd2, C_LW};
        tbl[11] = '{1'b1, 5'd8, 5'd3, 5'd9, 1'b1, C_ADD,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0};
        tbl[12] = '{1'b1, 5'd2, 5'd8, 5'd0, 1'b0, C_LW,   1'b0, 1'b0, 1'b0, 1'b1, 5'd2, C_LW};
        tbl[13] = '{1'b1, 5'd3, 5'd8, 5'd9, 1'b1, C_ADD,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 10'd0};
        tbl[14] = '{1'b1, 5'd2, 5'd8, 5'd0, 1'b0, C_LW,   1'b0, 1'b0, 1'b0, 1'b1, 5'd2, C_LW};
        tbl[15] = '{1'b1, 5'd3, 5'd8, 5'd9, 1'b0, C_ADD,  1'b0, 1'b0, 1'b0, 1'b1, 5'd3, C_ADD};

        m = '{default: '0};
        m_cnt = 0;
        rst_n = 1'b0;
        drive(1'b1, 5'd8, 5'd8, 5'd1, 1'b1, C_ADD, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_zero();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].u, tbl[i].ctrl, tbl[i].fl, tbl[i].ho);
            #1;
            chk($sformatf("tbl%0d.stall", i), stall_ID, tbl[i].e_stall);
            cycle();
            chk($sformatf("tbl%0d.valid", i), valid_IDEX, tbl[i].e_valid);
            chk($sformatf("tbl%0d.rs", i), regRs_IDEX, tbl[i].e_rs);
            chk($sformatf("tbl%0d.ctrl", i), ctrl_IDEX, tbl[i].e_ctrl);
        end

        // Load-use hazard while memory holds for three cycles.
        drive(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, C_LW, 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd8, 5'd3, 5'd9, 1'b1, C_ADD, 1'b0, 1'b1);
            #1;
            chk($sformatf("hold%0d.stall", k), stall_ID, 1);
            cycle();
            chk($sformatf("hold%0d.frozen", k), {valid_IDEX, regRs_IDEX, ctrl_IDEX}, {1'b1, 5'd2, C_LW});
        end
        drive(1'b1, 5'd8, 5'd3, 5'd9, 1'b1, C_ADD, 1'b0, 1'b0);
        #1;
        chk("hold.after.stall", stall_ID, 1);
        cycle();
        chk("hold.bubble", {valid_IDEX, ctrl_IDEX}, 0);
        #1;
        chk("hold.release.stall", stall_ID, 0);
        cycle();
        chk("hold.proceed", {valid_IDEX, regRs_IDEX}, {1'b1, 5'd8});

        // One more hazard bubble, then reset in the middle of a stall.
        drive(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, C_LW, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd8, 5'd3, 5'd9, 1'b1, C_ADD, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, C_LW, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd8, 5'd3, 5'd9, 1'b1, C_ADD, 1'b0, 1'b0);
        #1;
        chk("midrst.stall", stall_ID, 1);
`ifdef MIPS_IDEX_BUBBLE_CNT_EN
        chk("midrst.count5", bubbleCount, 5);
`endif
        rst_n = 1'b0;
        #1;
        check_zero();
        m = '{default: '0};
        m_cnt = 0;
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) != 0) ? C_LW : 10'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection. Captures decoded operands, register specifiers and control bits from ID at each clock edge. Drives `regRs_IDEX`/`regRt_IDEX` and the EX-side control consumed by the forwarding unit and ALU. Inserts a one-cycle bubble and stalls IF/ID whenever a load in EX feeds the instruction in ID, and supports flush on a taken branch and hold on a downstream memory stall.

## Interface
- `DATA_W`, 32: datapath width.
- `CTRL_W`, 10: control bundle width; bit layout fixed by `mips_pipe_pkg`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_ID` in 1: ID holds a real instruction.
- `regRs_ID`, `regRt_ID`, `regRd_ID` in 5 each: register specifiers from decode.
- `usesRt_ID` in 1: ID instruction reads rt as a source (R-type, store, beq/bne).
- `readData1_ID`, `readData2_ID`, `signExt_ID`, `pc4_ID` in DATA_W each: operands, immediate, PC+4.
- `ctrl_ID` in CTRL_W: decoded control bundle.
- `flush_EX` in 1: taken branch/jump resolved in EX; squash ID/EX.
- `hold_MEM` in 1: downstream memory stall; freeze ID/EX.
- `regRs_IDEX`, `regRt_IDEX`, `regRd_IDEX` out 5 each: registered specifiers.
- `readData1_IDEX`, `readData2_IDEX`, `signExt_IDEX`, `pc4_IDEX` out DATA_W each: registered data.
- `ctrl_IDEX` out CTRL_W: registered control; all zero for a bubble.
- `valid_IDEX` out 1: EX holds a real instruction.
- `stall_ID` out 1: combinational; freezes PC and IF/ID.
- `bubbleCount` out 32: only with `MIPS_IDEX_BUBBLE_CNT_EN`.

## Operation
- Hazard condition H: `valid_IDEX` & `ctrl_IDEX[CTRL_MEMREAD]` & `valid_ID` & `regRt_IDEX != 0` & (`regRt_IDEX == regRs_ID` | (`usesRt_ID` & `regRt_IDEX == regRt_ID`)).
- `stall_ID = (H | hold_MEM) & ~flush_EX`.
- Per-edge update priority, highest first:
  - `flush_EX`: load a bubble.
  - `hold_MEM`: keep all registers.
  - H: load a bubble.
  - Otherwise: load all ID inputs. `valid_IDEX <= valid_ID`; `ctrl_IDEX <= valid_ID ? ctrl_ID : 0`.
- Bubble: `valid_IDEX=0`, `ctrl_IDEX=0`. Specifier and data registers are also cleared to 0, so a bubble can never match in the forwarding unit.
- Write-disabled bubbles guarantee H clears after one bubble. A load-use stall therefore lasts exactly one cycle unless `hold_MEM` extends it.
- Specifier 0 never triggers H (load to $zero).

## Timing
- Latency: ID inputs appear on `*_IDEX` one cycle after a non-held, non-bubble edge.
- `stall_ID` is valid in the same cycle as the ID inputs and `*_IDEX` state. It has no registered delay.
- Reset (async assert, sync-safe deassert handled at top): every output is 0, including `bubbleCount`. `stall_ID` is 0 while in reset because `valid_IDEX`=0.
- Simultaneous `flush_EX` and H: flush wins; bubble loaded; `stall_ID`=0 so IF can redirect.
- Simultaneous `hold_MEM` and H: hold wins; registers frozen; `stall_ID`=1. H is re-evaluated after hold drops.
- Reset mid-stall: state clears immediately, and the stall drops in the same cycle.

## Configuration
- `MIPS_IDEX_BUBBLE_CNT_EN` defined: 32-bit `bubbleCount` increments on every edge that loads a bubble due to H, not flush. It wraps at 2^32-1 → 0, holds under `hold_MEM`, and clears on reset.
- Undefined: no port, no counter logic.

## Structure
- `mips_pipe_pkg` holds the control bit indices (`CTRL_REGWRITE`=0, `CTRL_MEMREAD`=1, `CTRL_MEMWRITE`=2, `CTRL_MEMTOREG`=3, `CTRL_REGDST`=4, `CTRL_ALUSRC`=5, `CTRL_ALUOP`=9:6), `CTRL_W`, and `REG_ZERO`=5'd0.
- One sub-module, `load_use_detect`: purely combinational, computes H from the IDEX and ID specifiers.

## Test plan
- lw $8 in EX, then add $9,$8,$3 in ID → `stall_ID`=1 for one cycle, one bubble (`valid_IDEX`=0, `ctrl_IDEX`=0), then add enters EX with `regRs_IDEX`=8.
- lw $0 in EX, then add using $0 in ID → `stall_ID`=0, no bubble.
- lw $8 in EX, then addi $8,$8,… with `usesRt_ID`=0 and rs=8 → stall. Same with rs=4, rt=8 → no stall.
- Load-use hazard with `flush_EX`=1 → bubble loaded, `stall_ID`=0. Under the macro, `bubbleCount` is unchanged.
- Load-use hazard with `hold_MEM`=1 for 3 cycles → registers frozen, `stall_ID`=1 for 3 cycles, then one bubble, then the dependent instruction proceeds.
- `rst_n` pulsed low mid-stall with `bubbleCount`=5 → all outputs 0 immediately, counter 0.
